// File: rtl/counter_snapshot_reader.sv
// counter_snapshot_reader: captures the Count0/Count1 pair on one edge and streams
//   the 128-bit snapshot out as 64/DATA_W words per counter, Count0 first, LS word first.
// Latency: first word valid 1 cycle after Req is sampled in IDLE; one word per cycle after that.
// Backpressure: Dout/Last hold while Dvalid && !Dready; Req is ignored while Busy.
//
// Ports:
//   Clk, Reset        - clock (rising edge), asynchronous active-low reset
//   Count0, Count1    - live 64-bit counters from the counter block
//   Req               - snapshot request, only looked at in IDLE
//   Dout/Dvalid/Dready- output word stream, valid/ready handshake
//   Last              - marks the final word of a snapshot
//   Busy              - request accepted, final word not yet transferred
//   Done              - one-cycle pulse after the final transfer
//
// Build option: COUNTER_SNAPSHOT_CHECKSUM_EN appends one extra word, the XOR of all
// data words, and moves Last onto it.
//
// DATA_W must be 8, 16, 32 or 64.

module counter_snapshot_reader #(
  parameter int DATA_W = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [63:0]       Count0,
  input  logic [63:0]       Count1,
  input  logic              Req,
  output logic [DATA_W-1:0] Dout,
  output logic              Dvalid,
  input  logic              Dready,
  output logic              Last,
  output logic              Busy,
  output logic              Done
);

  localparam int N     = 64 / DATA_W;
  localparam int NW    = 2 * N;
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
    ,
    CHK  = 2'd2
`endif
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [127:0]       snap;
  logic               capture;
  logic               done_nxt;
  logic               xfer;
  logic [DATA_W-1:0]  word_sel;

  assign Dvalid = (state != IDLE);
  assign Busy   = (state != IDLE);
  assign xfer   = Dvalid && Dready;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      idx   <= '0;
      snap  <= '0;
      Done  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      Done  <= done_nxt;
      if (capture) begin
        snap <= {Count1, Count0};
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    capture   = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (Req) begin
          capture   = 1'b1;
          idx_nxt   = '0;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx == LAST_IDX) begin
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = IDLE;
            done_nxt  = 1'b1;
`endif
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Constant-index mux keeps the word select free of variable part-selects.
  always_comb begin
    word_sel = '0;
    for (int k = 0; k < NW; k++) begin
      if (idx == IDX_W'(k)) begin
        word_sel = snap[k*DATA_W +: DATA_W];
      end
    end
  end

`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int k = 0; k < NW; k++) begin
      csum = csum ^ snap[k*DATA_W +: DATA_W];
    end
  end

  assign Last = (state == CHK);

  always_comb begin
    Dout = '0;
    if (state == SEND) begin
      Dout = word_sel;
    end else if (state == CHK) begin
      Dout = csum;
    end
  end
`else
  assign Last = (state == SEND) && (idx == LAST_IDX);

  // Gated to zero outside SEND so the reset value is 0 without a clock.
  always_comb begin
    Dout = '0;
    if (state == SEND) begin
      Dout = word_sel;
    end
  end
`endif

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// tb_counter_snapshot_reader: directed test of the snapshot reader at DATA_W=16.
// Latency: n/a (testbench).
// Backpressure: exercised by stalling Dready while word 2 is presented.

module tb_counter_snapshot_reader;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [63:0] Count0;
  logic [63:0] Count1;
  logic        Req;
  logic [15:0] Dout;
  logic        Dvalid;
  logic        Dready;
  logic        Last;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef COUNTER_SNAPSHOT_CHECKSUM_EN
  localparam int T = 9;
`else
  localparam int T = 8;
`endif

  // Count0=0x0123456789ABCDEF, Count1=5; last entry is the XOR of the first eight.
  logic [15:0] exp_a [9] = '{16'hCDEF, 16'h89AB, 16'h4567, 16'h0123,
                             16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0005};
  // Count0=0, Count1=5.
  logic [15:0] exp_b [9] = '{16'h0000, 16'h0000, 16'h0000, 16'h0000,
                             16'h0005, 16'h0000, 16'h0000, 16'h0000, 16'h0005};

  counter_snapshot_reader #(.DATA_W(16)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Count0 (Count0),
    .Count1 (Count1),
    .Req    (Req),
    .Dout   (Dout),
    .Dvalid (Dvalid),
    .Dready (Dready),
    .Last   (Last),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Walks words 0..T-1 of a snapshot already in SEND, checking each at negedge.
  task automatic drain(input bit use_b, input bit stall, input bit req_busy);
    for (int k = 0; k < T; k++) begin
      logic [15:0] e;
      e = use_b ? exp_b[k] : exp_a[k];
      @(negedge Clk);
      chk($sformatf("word%0d", k), Dout, e);
      chk($sformatf("dvalid%0d", k), Dvalid, 1);
      chk($sformatf("last%0d", k), Last, (k == T - 1));
      chk($sformatf("busy%0d", k), Busy, 1);
      chk($sformatf("done_low%0d", k), Done, 0);
      if (stall && k == 2) begin
        Dready = 1'b0;
        Count0 = 64'h0;
        repeat (4) begin
          @(negedge Clk);
          chk("stall_dout", Dout, e);
          chk("stall_dvalid", Dvalid, 1);
        end
        Dready = 1'b1;
      end
      Req = (req_busy && k == 3);
      @(posedge Clk);
    end
    #1 Req = 1'b0;
  endtask

  task automatic check_done();
    @(negedge Clk);
    chk("done_pulse", Done, 1);
    chk("done_dvalid", Dvalid, 0);
    chk("done_busy", Busy, 0);
    chk("done_last", Last, 0);
  endtask

  initial begin
    Reset  = 1'b0;
    Req    = 1'b0;
    Dready = 1'b0;
    Count0 = 64'h0123_4567_89AB_CDEF;
    Count1 = 64'h0000_0000_0000_0005;

    // Reset state
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_dout", Dout, 0);
    chk("rst_dvalid", Dvalid, 0);
    chk("rst_last", Last, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    Reset  = 1'b1;
    Dready = 1'b1;
    Req    = 1'b1;

    // Word order at full throughput; counters change right after capture
    @(posedge Clk);
    #1 Req = 1'b0;
    Count0 = 64'hDEAD_BEEF_0000_1111;
    Count1 = 64'hFFFF_FFFF_FFFF_FFFF;
    drain(1'b0, 1'b0, 1'b0);
    check_done();
    @(negedge Clk);
    chk("done_one_cycle", Done, 0);

    // Backpressure, coherence, Req while busy
    Count0 = 64'h0123_4567_89AB_CDEF;
    Count1 = 64'h0000_0000_0000_0005;
    Req    = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    drain(1'b0, 1'b1, 1'b1);
    check_done();

    // Req in the Done cycle starts a new snapshot (Count0 is now 0)
    Req = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge Clk);
      chk($sformatf("r3_word%0d", k), Dout, exp_b[k]);
      chk($sformatf("r3_dvalid%0d", k), Dvalid, 1);
      @(posedge Clk);
    end

    // Reset between edges while word 5 is presented
    @(negedge Clk);
    chk("r3_word5", Dout, exp_b[5]);
    #2 Reset = 1'b0;
    #1;
    chk("abort_dvalid", Dvalid, 0);
    chk("abort_busy", Busy, 0);
    chk("abort_last", Last, 0);
    chk("abort_dout", Dout, 0);
    @(posedge Clk);
    #3 Reset = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("abort_no_done", Done, 0);
      chk("abort_idle", Dvalid, 0);
    end

    // IDLE accepts a new request after the abort
    Req = 1'b1;
    @(posedge Clk);
    #1 Req = 1'b0;
    @(negedge Clk);
    chk("post_rst_dvalid", Dvalid, 1);
    chk("post_rst_word0", Dout, exp_b[0]);
    chk("post_rst_busy", Busy, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_snapshot_reader.md
Name: counter_snapshot_reader

Overview:
- Reads out the event-counter pair: Count0 (plain event count) and Count1 (prescaled event count), both 64 bits.
- On a request, captures both values in the same cycle.
- Streams the captured 128 bits out as a fixed sequence of narrow words over a valid/ready handshake.
- Sits between the counter block and the debug/telemetry link, so counters can keep running while a coherent snapshot drains.

Parameters:
- DATA_W, 16, width of each output word; legal values are 8, 16, 32 and 64 (must divide 64).

Ports:
- Clk  input  1  system clock, rising-edge active
- Reset  input  1  asynchronous, active-low reset
- Count0  input  64  live plain event count from the counter block
- Count1  input  64  live prescaled event count from the counter block
- Req  input  1  snapshot request; sampled only in IDLE
- Dout  output  DATA_W  current output word
- Dvalid  output  1  Dout holds a valid word
- Dready  input  1  downstream accepts the word
- Last  output  1  high with the final word of a snapshot
- Busy  output  1  high from request acceptance until the final transfer
- Done  output  1  one-cycle pulse after the final transfer

Behaviour:
- Clock and reset: Clk is the single clock. Reset is asynchronous and active-low.
- Reset values (Reset low, effective immediately, no clock needed): Dout=0, Dvalid=0, Last=0, Busy=0, Done=0, word index=0, snapshot registers=0, state=IDLE.
- Word count: N = 64/DATA_W words per counter; total words T = 2N (T+1 with the optional feature).
- Word order, index k:
  - k<N: Count0_snap[k*DATA_W +: DATA_W], least significant word first.
  - N<=k<2N: Count1_snap[(k-N)*DATA_W +: DATA_W].
- States: IDLE, SEND (plus CHK when the optional feature is compiled in).
- IDLE:
  - Req=1 at a rising edge: snapshot Count0/Count1 from that same edge, index=0, Busy=1, go to SEND.
  - Dvalid=1 with word 0 from the next cycle on (latency 1 cycle from Req to first valid word).
- SEND:
  - A transfer occurs at a rising edge where Dvalid=1 and Dready=1.
  - While Dvalid=1 and Dready=0, Dout and Last hold stable. Dvalid never drops without a transfer.
  - One word per cycle at full throughput when Dready is held high.
  - Last=1 exactly while the final word (index T-1) is presented.
  - On the final transfer: go to IDLE; next cycle Dvalid=0, Last=0, Busy=0, Done=1 for one cycle.
- Req handling:
  - Req while Busy=1 is ignored; it is not queued.
  - Req in the cycle Done=1 is accepted (state is IDLE).
- Counter changes after the snapshot edge never affect words already captured.
- Reset mid-snapshot aborts immediately: Dvalid drops asynchronously and there is no Done pulse.
- Dready is ignored when Dvalid=0.

Optional Feature:
- Macro: COUNTER_SNAPSHOT_CHECKSUM_EN.
- Defined:
  - After word 2N-1 transfers, enter CHK and present one extra word, equal to the XOR of all 2N data words.
  - Last moves to the checksum word; T = 2N+1.
- Undefined: no CHK state; Last accompanies word 2N-1; T = 2N.

Test Plan (DATA_W=16):
- Reset check: hold Reset=0 for 3 cycles -> all outputs 0. Release Reset and drive Req=1 for 1 cycle -> Dvalid=1 on the next cycle, Busy=1.
- Word order: Count0=0x0123456789ABCDEF, Count1=0x0000000000000005, Dready=1 -> Dout sequence CDEF, 89AB, 4567, 0123, 0005, 0000, 0000, 0000 on 8 consecutive cycles. Last high only on the 8th word; Done pulses the next cycle.
- Optional feature: same stimulus with COUNTER_SNAPSHOT_CHECKSUM_EN defined -> 9th word 0x0005 with Last=1; Last=0 on the 8th word.
- Backpressure and coherence:
  - Dready=0 for 4 cycles while word 2 is presented -> Dout stays 0x4567, Dvalid stays 1.
  - Change Count0 to 0 during the transfer -> the remaining words are still from the snapshot.
- Req while busy: Req=1 during word 3 -> ignored, exactly 8 words sent. Req=1 in the Done cycle -> a new snapshot starts, Dvalid=1 the next cycle.
- Reset mid-snapshot: assert Reset=0 between clock edges during word 5 -> Dvalid, Busy, Last drop immediately; no Done pulse. After release, IDLE accepts a new Req.
